// File: rtl/fp_mul_pkg.sv
// Shared types and bit positions for the FP multiplier flag pipeline.
// Used by fp_operand_class, fp_mul_flag_pipe_if and fp_mul_flag_pipe.
package fp_mul_pkg;

  localparam int FLAG_W   = 12;
  localparam int STATUS_W = 5;

  localparam int FLG_P_DN    = 0;
  localparam int FLG_P_Z     = 1;
  localparam int FLG_P_INF   = 2;
  localparam int FLG_P_NAN   = 3;
  localparam int FLG_OF      = 4;
  localparam int FLG_UF      = 5;
  localparam int FLG_RND     = 6;
  localparam int FLG_PM_ONES = 7;
  localparam int FLG_A_NAN   = 8;
  localparam int FLG_A_INF   = 9;
  localparam int FLG_A_DN    = 10;
  localparam int FLG_A_Z     = 11;

  localparam int ST_DN = 0;
  localparam int ST_NX = 1;
  localparam int ST_UF = 2;
  localparam int ST_OF = 3;
  localparam int ST_NV = 4;

  typedef struct packed {
    logic z;
    logic dn;
    logic inf;
    logic nan;
  } op_class_t;

  typedef struct packed {
    op_class_t a;
    op_class_t b;
    logic      pm_ones;
    logic      rnd;
    logic      uf;
    logic      of;
    logic      gs;
  } s1_t;

  // Special products (NaN/Inf/zero) suppress the range and inexact exceptions.
  function automatic logic [STATUS_W-1:0] accrue_bits(input logic [FLAG_W-1:0] f,
                                                      input logic gs);
    logic special;
    logic [STATUS_W-1:0] s;
    special  = f[FLG_P_NAN] | f[FLG_P_INF] | f[FLG_P_Z];
    s        = '0;
    s[ST_NV] = f[FLG_P_NAN];
    s[ST_OF] = f[FLG_OF] & ~special;
    s[ST_UF] = f[FLG_UF] & ~special;
    s[ST_NX] = (f[FLG_RND] | gs | f[FLG_OF] | f[FLG_UF]) & ~special;
    s[ST_DN] = f[FLG_P_DN];
    return s;
  endfunction

endpackage

// File: rtl/fp_mul_flag_pipe_if.sv
// Handshake bundle between the multiplier datapath (master) and the flag pipe (slave).
interface fp_mul_flag_pipe_if
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                 in_valid;
  logic                 in_ready;
  logic [EXP_W-1:0]     ea;
  logic [MAN_W-1:0]     ma;
  logic [EXP_W-1:0]     eb;
  logic [MAN_W-1:0]     mb;
  logic [EXP_W+1:0]     pe;
  logic                 pm_lsb;
  logic [MAN_W:0]       pm_low;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLAG_W-1:0]    flags;
  logic                 clr_status;
  logic [STATUS_W-1:0]  status;

  modport master (
    output in_valid, ea, ma, eb, mb, pe, pm_lsb, pm_low, out_ready, clr_status,
    input  in_ready, out_valid, flags, status
  );

  modport slave (
    input  in_valid, ea, ma, eb, mb, pe, pm_lsb, pm_low, out_ready, clr_status,
    output in_ready, out_valid, flags, status
  );
endinterface

// File: rtl/DRegister.sv
// Enabled D register with synchronous active-high clear.
module DRegister #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/fp_operand_class.sv
// Combinational IEEE operand classifier: zero, denormal, infinity, NaN.
module fp_operand_class
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exponent,
  input  logic [MAN_W-1:0] fraction,
  output op_class_t        cls
);
  logic exp_zero, exp_ones, frac_zero;

  assign exp_zero  = ~|exponent;
  assign exp_ones  = &exponent;
  assign frac_zero = ~|fraction;

  assign cls.z   = exp_zero & frac_zero;
  assign cls.dn  = exp_zero & ~frac_zero;
  assign cls.inf = exp_ones & frac_zero;
  assign cls.nan = exp_ones & ~frac_zero;
endmodule

// File: rtl/fp_mul_flag_pipe.sv
// Two-stage special-case/rounding flag pipeline beside the mantissa multiplier.
// Accrued exception status exists only when FPMUL_FLAG_ACCRUE_EN is defined.
module fp_mul_flag_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_mul_flag_pipe_if.slave bus
);
  op_class_t cls_a, cls_b;
  s1_t s1_d, s1_q;
  logic s1_valid, s2_valid, adv1, adv2, hs_in;
  logic guard, sticky;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W:0] s2_q;
  logic s2_gs;

  fp_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .exponent(bus.ea), .fraction(bus.ma), .cls(cls_a));
  fp_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .exponent(bus.eb), .fraction(bus.mb), .cls(cls_b));

  // in_ready looks through both stages so a full pipe still accepts when the sink drains.
  assign adv2         = ~s2_valid | bus.out_ready;
  assign adv1         = ~s1_valid | adv2;
  assign hs_in        = adv1 & bus.in_valid;
  assign bus.in_ready = adv1;

  assign guard  = bus.pm_low[MAN_W];
  assign sticky = |bus.pm_low[MAN_W-1:0];

  always_comb begin
    s1_d.a       = cls_a;
    s1_d.b       = cls_b;
    s1_d.pm_ones = &bus.ma;
    s1_d.rnd     = guard & (bus.pm_lsb | sticky);
    s1_d.uf      = bus.pe[EXP_W+1];
    s1_d.of      = ~bus.pe[EXP_W+1] & (bus.pe[EXP_W] | &bus.pe[EXP_W-1:0]);
    s1_d.gs      = guard | sticky;
  end

  DRegister #(.W(1)) u_s1_valid (
    .clk(clk), .rst(rst), .en(adv1), .d(bus.in_valid), .q(s1_valid));
  DRegister #(.W($bits(s1_t))) u_s1_data (
    .clk(clk), .rst(rst), .en(hs_in), .d(s1_d), .q(s1_q));

  always_comb begin
    flags_d              = '0;
    flags_d[FLG_A_Z]     = s1_q.a.z;
    flags_d[FLG_A_DN]    = s1_q.a.dn;
    flags_d[FLG_A_INF]   = s1_q.a.inf;
    flags_d[FLG_A_NAN]   = s1_q.a.nan;
    flags_d[FLG_PM_ONES] = s1_q.pm_ones;
    flags_d[FLG_RND]     = s1_q.rnd;
    flags_d[FLG_UF]      = s1_q.uf;
    flags_d[FLG_OF]      = s1_q.of;
    flags_d[FLG_P_NAN]   = s1_q.a.nan | s1_q.b.nan | (s1_q.a.inf & s1_q.b.z)
                         | (s1_q.a.z & s1_q.b.inf);
    flags_d[FLG_P_INF]   = (s1_q.a.inf & ~(s1_q.b.nan | s1_q.b.z))
                         | (s1_q.b.inf & ~(s1_q.a.nan | s1_q.a.z));
    flags_d[FLG_P_Z]     = (s1_q.a.z & ~(s1_q.b.nan | s1_q.b.inf))
                         | (s1_q.b.z & ~(s1_q.a.nan | s1_q.a.inf));
    flags_d[FLG_P_DN]    = s1_q.a.dn | s1_q.b.dn;
  end

  // All flags plus the carried guard/sticky move as one word so a beat never mixes stages.
  DRegister #(.W(1)) u_s2_valid (
    .clk(clk), .rst(rst), .en(adv2), .d(s1_valid), .q(s2_valid));
  DRegister #(.W(FLAG_W + 1)) u_s2_data (
    .clk(clk), .rst(rst), .en(adv2 & s1_valid), .d({flags_d, s1_q.gs}), .q(s2_q));

  assign bus.flags     = s2_q[FLAG_W:1];
  assign s2_gs         = s2_q[0];
  assign bus.out_valid = s2_valid;

`ifdef FPMUL_FLAG_ACCRUE_EN
  logic hs_out;
  logic [STATUS_W-1:0] beat_bits, status_q;

  assign hs_out    = s2_valid & bus.out_ready;
  assign beat_bits = accrue_bits(bus.flags, s2_gs);

  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else if (bus.clr_status) status_q <= hs_out ? beat_bits : '0;
    else if (hs_out) status_q <= status_q | beat_bits;
  end

  assign bus.status = status_q;
`else
  logic unused_accrue;
  assign unused_accrue = s2_gs ^ bus.clr_status;
  assign bus.status    = '0;
`endif
endmodule
